dcache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipeline's DCACHE_* port and the slow data memory.
- Consumes the word-addressed read/write requests issued from the pipeline MEM stage.
- Returns read data combinationally on a hit.
- Holds proc_stall high while it writes back a dirty victim and/or refills a 4-word line.

---
 rtl/dcache_wb_dm.sv | 130 +++++++++++++
 tb/tb_dcache_wb_dm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// The processor side answers hits combinationally; misses stall while a line is written back/refilled.
module dcache_wb_dm #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned Lines = 2 ** INDEX_W;
  localparam int unsigned TagW  = 28 - INDEX_W;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e             state_q, state_d;
  logic [Lines-1:0]   valid_q, dirty_q;
  logic [TagW-1:0]    tag_q [Lines];
  logic [127:0]       data_q [Lines];
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [27:0]        mem_addr_q, mem_addr_d;
  logic [127:0]       mem_wdata_q, mem_wdata_d;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TagW-1:0]    tag;
  logic [127:0]       line;
  logic               req, hit;

  assign offset = proc_addr[1:0];
  assign index  = proc_addr[INDEX_W+1:2];
  assign tag    = proc_addr[29:INDEX_W+2];
  assign line   = data_q[index];
  assign req    = proc_read | proc_write;
  assign hit    = valid_q[index] & (tag_q[index] == tag);

  assign proc_stall = req & ~((state_q == StIdle) & hit);
  assign proc_rdata = line[{offset, 5'd0} +: 32];

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          if (valid_q[index] && dirty_q[index]) begin
            state_d     = StWriteback;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[index], index};
            mem_wdata_d = line;
          end else begin
            state_d    = StAllocate;
            mem_read_d = 1'b1;
            mem_addr_d = proc_addr[29:2];
          end
        end
      end
      StWriteback: begin
        // Request is held stable by the pipeline, so the refill address is still valid here.
        if (mem_ready) begin
          state_d     = StAllocate;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[29:2];
        end
      end
      StAllocate: begin
        if (mem_ready) begin
          state_d    = StIdle;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      // Arrays are cleared too so no output ever shows undefined data.
      for (int i = 0; i < int'(Lines); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == StIdle && proc_write && hit) begin
        data_q[index][{offset, 5'd0} +: 32] <= proc_wdata;
        dirty_q[index]                       <= 1'b1;
      end
      if (state_q == StAllocate && mem_ready) begin
        data_q[index]  <= mem_rdata;
        tag_q[index]   <= tag;
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Scoreboard bench for dcache_wb_dm: a flat word memory plus a tag/valid/dirty model predict
// read data, memory transactions and stall lengths; a memory model answers with random latency.
module tb_dcache_wb_dm;

  localparam int unsigned IndexW  = 3;
  localparam int          Timeout = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  dcache_wb_dm #(.INDEX_W(IndexW)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] backing [logic [27:0]];
  logic [31:0]  ref_mem [logic [29:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  mem_txn_t     mem_exp_q [$];
  logic [31:0]  exp_q [$];
  int           fixed_lat = -1;
  int           last_wb_lat = 0;
  int           last_rd_lat = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [29:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    if (backing.exists(la)) return backing[la];
    for (int i = 0; i < 4; i++) l[32*i +: 32] = def_word({la, 2'(i)});
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    logic [127:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = mem_line(a[29:2]);
    return l[{a[1:0], 5'd0} +: 32];
  endfunction

  // Predict memory traffic for one access from the direct-mapped cache rules and update the model.
  task automatic plan(input logic [29:0] a, input bit wr, output bit hit, output bit dv);
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [127:0] vl;
    mem_txn_t     t;
    idx = a[4:2];
    tg  = a[29:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    dv  = !hit && m_valid[idx] && m_dirty[idx];
    if (dv) begin
      for (int i = 0; i < 4; i++) vl[32*i +: 32] = ref_rd({m_tag[idx], idx, 2'(i)});
      t.wr = 1'b1; t.addr = {m_tag[idx], idx}; t.data = vl;
      mem_exp_q.push_back(t);
    end
    if (!hit) begin
      t.wr = 1'b0; t.addr = a[29:2]; t.data = '0;
      mem_exp_q.push_back(t);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) m_dirty[idx] = 1'b1;
  endtask

  // kind: 0 read, 1 write, 2 read+write (behaves as write)
  task automatic access(input int kind, input logic [29:0] a, input logic [31:0] d);
    bit hit, dv, wr;
    int cyc, exp_cyc;
    wr = (kind != 0);
    plan(a, wr, hit, dv);
    proc_read  = (kind != 1);
    proc_write = (kind != 0);
    proc_addr  = a;
    proc_wdata = d;
    if (!wr) exp_q.push_back(ref_rd(a));
    else ref_mem[a] = d;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!proc_stall) break;
      cyc++;
      if (cyc > Timeout) begin
        n_checks++;
        n_fail++;
        $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, cyc);
        break;
      end
    end
    if (cyc <= Timeout) begin
      exp_cyc = hit ? 0 : (dv ? 3 + last_wb_lat + last_rd_lat : 2 + last_rd_lat);
      check("stall_cycles", cyc, exp_cyc);
      if (hit) check("hit_no_mem", {mem_read, mem_write}, 2'b00);
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_mem.delete();
  endtask

  // Memory model: answers each line request with a latency, checks it against the plan and holds.
  initial begin : mem_model
    mem_txn_t     t;
    bit           was_wb, abort;
    int           lat;
    logic         cr, cw;
    logic [27:0]  ca;
    logic [127:0] cd;
    was_wb    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (was_wb && !rst) check("wb_mem_write_drops", mem_write, 1'b0);
      was_wb = 1'b0;
      if (!rst && (mem_read || mem_write)) begin
        cr = mem_read; cw = mem_write; ca = mem_addr; cd = mem_wdata;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        if (mem_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mem_req_unexpected: got rd=%0b wr=%0b addr %0h, required none", cr, cw, ca);
        end else begin
          t = mem_exp_q.pop_front();
          check("mem_kind", {cr, cw}, t.wr ? 2'b01 : 2'b10);
          check("mem_addr", ca, t.addr);
          if (t.wr) check("mem_wdata", cd, t.data);
        end
        if (cw) last_wb_lat = lat;
        else last_rd_lat = lat;
        abort = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          check("hold_mem_rw", {mem_read, mem_write}, {cr, cw});
          check("hold_mem_addr", mem_addr, ca);
          check("hold_mem_wdata", mem_wdata, cd);
          if (proc_read || proc_write) check("stall_held", proc_stall, 1'b1);
        end
        if (!abort) begin
          mem_ready = 1'b1;
          if (cr) begin
            mem_rdata = mem_line(ca);
          end else begin
            backing[ca] = cd;
            was_wb      = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every completed read is popped and compared.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && proc_read && !proc_write && !proc_stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_unexpected: got data %0h, required no read completion", proc_rdata);
        end else begin
          check("read_data", proc_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit hit, dv;
    logic [29:0] a;
    int r;
    rst        = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_stall", proc_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    backing[28'h4] = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
    fixed_lat = 3;
    access(0, 30'h10, 32'h0);
    fixed_lat = -1;
    access(0, 30'h13, 32'h0);
    access(1, 30'h11, 32'hDEAD_BEEF);
    access(0, 30'h31, 32'h0);
    access(1, 30'h20, 32'h1234_5678);
    access(0, 30'h40, 32'h0);

    // Reset while a refill is outstanding.
    plan(30'h14, 1'b0, hit, dv);
    fixed_lat  = 20;
    proc_read  = 1'b1;
    proc_addr  = 30'h14;
    repeat (3) @(negedge clk);
    check("refill_pending", mem_read, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    proc_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("midrst_mem_addr", mem_addr, 28'h0);
    check("midrst_mem_wdata", mem_wdata, 128'h0);
    model_reset();
    fixed_lat = -1;
    @(posedge clk);
    #1;
    access(0, 30'h14, 32'h0);

    // Slow memory on both legs of a dirty miss.
    access(1, 30'h15, 32'hCAFE_F00D);
    fixed_lat = 10;
    access(0, 30'h34, 32'h0);
    fixed_lat = -1;

    for (int n = 0; n < 300; n++) begin
      a = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      a = {2'b00, a[29:2]};
      r = int'($urandom_range(0, 9));
      access((r < 5) ? 0 : (r < 9) ? 1 : 2, a, $urandom);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("mem_plan_drained", mem_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
